spi_master_tx: RTL and testbench

//   Mode-0 (CPOL=0, CPHA=0), MSB-first SPI master that drives the board's SPI

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_gen.sv | 50 +++++
 rtl/spi_master_tx.sv | 202 ++++++++++++++++++++
 tb/tb_spi_master_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI mode constants and master FSM state encoding shared with the slave side
package spi_pkg;

  // Mode 0: SCLK idles low, data is sampled on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 3'd0;
  localparam spi_state_t ST_SETUP = 3'd1;
  localparam spi_state_t ST_SHIFT = 3'd2;
  localparam spi_state_t ST_NEXT  = 3'd3;
  localparam spi_state_t ST_HOLD  = 3'd4;
  localparam spi_state_t ST_GAP   = 3'd5;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK half-period timer producing rise/fall strobes for the master FSM
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          tick;

  // A strobe fires on the last cycle of each half period; phase says which edge it is.
  assign tick   = en_i && (cnt_q == HALF_LAST);
  assign rise_o = tick && !phase_q;
  assign fall_o = tick && phase_q;

  // Count while enabled; when disabled, restart so the next word begins with a full low half.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end else begin
      cnt_d = cnt_q + HW'(1);
    end
  end

  // Half-period counter and edge phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - mode-0 MSB-first SPI master fed by a word stream, full-duplex rx
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  input  logic              tx_last_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              spi_clk_o,
  output logic              spi_ss_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  localparam int PH_MAX = (SS_SETUP > SS_HOLD)
                          ? ((SS_SETUP > IDLE_GAP) ? SS_SETUP : IDLE_GAP)
                          : ((SS_HOLD  > IDLE_GAP) ? SS_HOLD  : IDLE_GAP);
  localparam int CW = $clog2(PH_MAX + 1);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(SS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              last_q, last_d;
  logic              ss_q, ss_d;
  logic              sclk_q, sclk_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d;
  logic              miso_s1_q, miso_s2_q;
  logic              rise_s, fall_s, sample_s;
  logic              ready, accept;

  // Ready is decoded from state; it is held low while reset is applied.
  assign ready      = !rst && ((state_q == ST_IDLE) || (state_q == ST_NEXT));
  assign accept     = tx_valid_i && ready;
  assign tx_ready_o = ready;

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign spi_clk_o  = sclk_q;
  assign spi_ss_o   = ss_q;
  assign mosi_o     = tx_sh_q[DATA_W-1];

  // The shift register MSB drives MOSI, so the word shifts left once per falling edge.
  assign sample_s = (SPI_CPHA == 1'b0) ? rise_s : fall_s;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_SHIFT),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Two-flop synchroniser on MISO; the slave is clocked from our SCLK, not clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= miso_i;
      miso_s2_q <= miso_s1_q;
    end
  end

  // Frame sequencing: SS setup, per-bit SCLK/shift, word hand-off, SS hold and idle gap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    ss_d       = ss_q;
    sclk_d     = sclk_q;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          tx_sh_d = tx_data_i;
          last_d  = tx_last_i;
          ss_d    = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        if (sample_s) begin
          rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_s2_q};
        end
        if (rise_s) begin
          sclk_d = !SPI_CPOL;
        end
        if (fall_s) begin
          sclk_d = SPI_CPOL;
          if (bit_q == BIT_LAST) begin
            bit_d      = '0;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            state_d    = last_q ? ST_HOLD : ST_NEXT;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      ST_NEXT: begin
        // SS stays asserted; the frame simply waits here for the next word.
        if (accept) begin
          tx_sh_d = tx_data_i;
          last_d  = tx_last_i;
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          ss_d    = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ss_d    = 1'b1;
        sclk_d  = SPI_CPOL;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      ss_q       <= 1'b1;
      sclk_q     <= SPI_CPOL;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      ss_q       <= ss_d;
      sclk_q     <= sclk_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - scoreboard bench for spi_master_tx with loopback and constant-MISO instances
`timescale 1ns/1ps
module tb_spi_master_tx;

  localparam int DW       = 8;
  localparam int DIV      = 4;
  localparam int SETUP    = 2;
  localparam int HOLD     = 2;
  localparam int GAP      = 2;
  localparam int WORD_CYC = 2 * DW * DIV;

  typedef struct {
    int len;
    int rises;
    int gap;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic       tx_ready, rx_valid, busy, sclk, ss, mosi;
  logic [7:0] rx_data;
  logic [7:0] tx1_data = 8'h00;
  logic       tx1_valid = 1'b0, tx1_last = 1'b0;
  logic       tx1_ready, rx1_valid, busy1, sclk1, ss1, mosi1;
  logic [7:0] rx1_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$], mosi_q[$], exp1_q[$], words[$];
  frame_t     exp_frames[$];

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_W(DW), .CLK_DIV(DIV), .SS_SETUP(SETUP), .SS_HOLD(HOLD), .IDLE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_last_i(tx_last),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
    .spi_clk_o(sclk), .spi_ss_o(ss), .mosi_o(mosi), .miso_i(mosi)
  );

  spi_master_tx #(.DATA_W(DW), .CLK_DIV(1), .SS_SETUP(SETUP), .SS_HOLD(HOLD), .IDLE_GAP(GAP)) dut1 (
    .clk(clk), .rst(rst), .tx_data_i(tx1_data), .tx_valid_i(tx1_valid), .tx_last_i(tx1_last),
    .tx_ready_o(tx1_ready), .rx_data_o(rx1_data), .rx_valid_o(rx1_valid), .busy_o(busy1),
    .spi_clk_o(sclk1), .spi_ss_o(ss1), .mosi_o(mosi1), .miso_i(1'b1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not expected or bound expired", name);
  endtask

  // Wait for a handshake on the chosen instance; returns at the negedge after the accepting edge.
  task automatic wait_accept(input int sel);
    logic r;
    bit   acc = 0;
    for (int i = 0; i < 2000 && !acc; i++) begin
      r = (sel != 0) ? tx1_ready : tx_ready;
      @(posedge clk);
      if (r) acc = 1;
      else @(negedge clk);
    end
    if (!acc) note_fail("accept_timeout");
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input logic last);
    tx_data  = w;
    tx_last  = last;
    tx_valid = 1'b1;
    rx_q.push_back(w);
    mosi_q.push_back(w);
    wait_accept(0);
  endtask

  // Sends the queued words as one frame presented back-to-back; SS must stay low
  // for setup + n words + one hand-off cycle between words + hold.
  task automatic send_frame(input int gap);
    frame_t f;
    int     n = words.size();
    f.len   = SETUP + WORD_CYC * n + (n - 1) + HOLD;
    f.rises = DW * n;
    f.gap   = gap;
    exp_frames.push_back(f);
    for (int i = 0; i < n; i++) send_word(words[i], (i == n - 1));
    words.delete();
  endtask

  task automatic wait_idle();
    int i = 0;
    while (!(busy == 1'b0 && ss == 1'b1) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 3000) note_fail("idle_timeout");
    repeat (GAP + 2) @(negedge clk);
  endtask

  // Rx scoreboard for the loopback instance: every strobe must match the oldest sent word.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (rx_q.size() == 0) note_fail("rx_unexpected");
      else chk("rx_data", rx_data, rx_q.pop_front());
    end
  end

  // Rx scoreboard for the CLK_DIV=1 instance.
  always @(negedge clk) begin
    if (!rst && rx1_valid) begin
      if (exp1_q.size() == 0) note_fail("rx1_unexpected");
      else chk("rx1_data", rx1_data, exp1_q.pop_front());
    end
  end

  // Line monitor: rebuilds words from MOSI at SCLK rises and measures SS low/high runs.
  logic       in_frame = 1'b0, sclk_prev = 1'b0;
  int         low_cnt = 0, rises = 0, hi_cnt = -1, cur_gap = -1, nbits = 0;
  logic [7:0] bits = 8'h00;
  frame_t     fm;
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0; low_cnt = 0; rises = 0; hi_cnt = -1; nbits = 0;
    end else if (!ss) begin
      if (!in_frame) begin
        in_frame = 1'b1; low_cnt = 0; rises = 0; cur_gap = hi_cnt;
      end
      low_cnt++;
      if (sclk && !sclk_prev) begin
        rises++;
        bits = {bits[6:0], mosi};
        nbits++;
        if (nbits == DW) begin
          nbits = 0;
          if (mosi_q.size() == 0) note_fail("mosi_unexpected");
          else chk("mosi_word", bits, mosi_q.pop_front());
        end
      end
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        if (exp_frames.size() == 0) note_fail("frame_unexpected");
        else begin
          fm = exp_frames.pop_front();
          if (fm.len >= 0) chk("frame_ss_low_cycles", low_cnt, fm.len);
          chk("frame_sclk_rises", rises, fm.rises);
          if (fm.gap >= 0) chk("frame_ss_high_gap", cur_gap, fm.gap);
        end
        hi_cnt = 0;
      end
      if (hi_cnt >= 0) hi_cnt++;
    end
    sclk_prev = sclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int     c, k, r, bad, maxhi, hi;
    logic   prev;
    frame_t f;

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    chk("rst_sclk", sclk, 0);       chk("rst_ss", ss, 1);
    chk("rst_mosi", mosi, 0);       chk("rst_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0); chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst1_ss", ss1, 1);         chk("rst1_mosi", mosi1, 0);
    chk("rst1_ready", tx1_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", tx_ready, 1);

    // 1: single 0xA5 frame with loopback.
    words.push_back(8'hA5);
    send_frame(-1);
    tx_valid = 1'b0;
    c = 1;
    while (!rx_valid && c < 500) begin @(negedge clk); c++; end
    chk("t1_accept_to_rx_valid", c, SETUP + WORD_CYC + 1);
    c = 0; k = 0;
    while (!tx_ready && k < 500) begin
      if (ss) c++;
      @(negedge clk);
      k++;
    end
    chk("t1_ss_high_before_ready", c, GAP);
    wait_idle();

    // 2: two words in one frame.
    words.push_back(8'h3C); words.push_back(8'hC3);
    send_frame(-1);
    tx_valid = 1'b0;
    wait_idle();

    // 3: stall between words of one frame.
    f.len = -1; f.rises = 2 * DW; f.gap = -1;
    exp_frames.push_back(f);
    send_word(8'h11, 1'b0);
    tx_valid = 1'b0;
    k = 0;
    while (!rx_valid && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) note_fail("t3_rx_timeout");
    bad = 0;
    repeat (50) begin
      if (!(ss == 1'b0 && sclk == 1'b0 && tx_ready == 1'b1 && busy == 1'b1)) bad++;
      @(negedge clk);
    end
    chk("t3_stall_violations", bad, 0);
    send_word(8'h22, 1'b1);
    tx_valid = 1'b0;
    wait_idle();

    // 4: reset on the third SCLK rise of an unexpected-response frame.
    tx_data = 8'h5A; tx_last = 1'b1; tx_valid = 1'b1;
    wait_accept(0);
    tx_valid = 1'b0;
    r = 0; k = 0; prev = sclk;
    while (r < 3 && k < 500) begin
      @(posedge clk); #1;
      if (sclk && !prev) r++;
      prev = sclk;
      k++;
    end
    chk("t4_rises_before_reset", r, 3);
    rst = 1'b1;
    #1;
    chk("t4_ss", ss, 1);           chk("t4_sclk", sclk, 0);
    chk("t4_mosi", mosi, 0);       chk("t4_busy", busy, 0);
    chk("t4_ready", tx_ready, 0);  chk("t4_rx_valid", rx_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    repeat (80) @(negedge clk);
    chk("t4_idle_after_reset", busy, 0);

    // 5: CLK_DIV=1 instance with MISO tied high.
    tx1_data = 8'h96; tx1_last = 1'b1; tx1_valid = 1'b1;
    exp1_q.push_back(8'hFF);
    wait_accept(1);
    tx1_valid = 1'b0;
    c = 1; r = 0; prev = sclk1; hi = 0; maxhi = 0;
    while (!rx1_valid && c < 200) begin
      if (sclk1) begin hi++; if (hi > maxhi) maxhi = hi; end else hi = 0;
      if (sclk1 && !prev) r++;
      prev = sclk1;
      @(negedge clk);
      c++;
    end
    chk("t5_accept_to_rx_valid", c, SETUP + 2 * DW + 1);
    chk("t5_rises", r, DW);
    chk("t5_sclk_high_run", maxhi, 1);
    repeat (10) @(negedge clk);
    chk("t5_idle", busy1, 0);

    // Random multi-word frames, presented continuously.
    for (int fr = 0; fr < 12; fr++) begin
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) words.push_back(8'($urandom()));
      send_frame((fr == 0) ? -1 : GAP + 1);
    end
    tx_valid = 1'b0;
    wait_idle();

    // 6: 100 single-word frames with tx_valid held high throughout.
    for (int fr = 0; fr < 100; fr++) begin
      words.push_back(8'($urandom()));
      send_frame((fr == 0) ? -1 : GAP + 1);
    end
    tx_valid = 1'b0;
    wait_idle();

    repeat (20) @(negedge clk);
    chk("rx_queue_drained", rx_q.size(), 0);
    chk("mosi_queue_drained", mosi_q.size(), 0);
    chk("frame_queue_drained", exp_frames.size(), 0);
    chk("rx1_queue_drained", exp1_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
